// File: rtl/iterative_shifter_pkg.sv
// Shared types and default sizing for the iterative shift unit.
package shifter_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational one-bit shift of a WIDTH vector; reserved op passes the value through.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (shift_op_t'(op))
      OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multicycle SLL/SRL/SRA unit, one bit per clock; FAST_SHIFT_EN swaps in a single-cycle barrel shift.
// Latency: done in the (1+shamt)th cycle after the start edge (always 1 with FAST_SHIFT_EN, shamt=0 or op=11).
// Backpressure: none; start is ignored while busy, including the done cycle.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  shift_state_t       state, state_nxt;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step_q;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op_q;
  logic               direct;
  logic [WIDTH-1:0]   direct_res;
  logic               last_step;

  assign last_step = (cnt == SHAMT_W'(1));

`ifdef FAST_SHIFT_EN
  // Whole shift resolved at capture, so every request goes straight to DONE.
  always_comb begin
    direct     = 1'b1;
    direct_res = data_in;
    case (shift_op_t'(op))
      OP_SLL:  direct_res = data_in << shamt;
      OP_SRL:  direct_res = data_in >> shamt;
      OP_SRA:  direct_res = WIDTH'($signed(data_in) >>> shamt);
      default: direct_res = data_in;
    endcase
  end
`else
  always_comb begin
    direct     = (shamt == '0) || (shift_op_t'(op) == OP_RSVD);
    direct_res = data_in;
  end
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op (op_q),
    .d  (work),
    .q  (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = direct ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // data_out is loaded on the edge entering DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      work     <= '0;
      cnt      <= '0;
      op_q     <= 2'b00;
      data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work <= data_in;
            op_q <= op;
            cnt  <= shamt;
            if (direct) data_out <= direct_res;
          end
        end
        S_SHIFT: begin
          work <= step_q;
          cnt  <= cnt - SHAMT_W'(1);
          if (last_step) data_out <= step_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench: directed table, in-flight reset sequence and random ops against an arithmetic model.
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  iterative_shifter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  sh;
    logic [31:0] din;
    logic [31:0] expv;
    int          lat;
    bit          noise;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Shifts as multiplication / floor division by a power of two.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input int sh, input logic [31:0] d);
    longint p;
    longint s;
    longint unsigned u;
    p = 64'sd1 <<< sh;
    u = {32'd0, d};
    case (o)
      2'b00: return 32'((u * 64'(p)) & 64'hFFFF_FFFF);
      2'b01: return 32'(u / 64'(p));
      2'b10: begin
        s = longint'($signed(d));
        if (s >= 0) s = s / p;
        else        s = -(((-s) + p - 1) / p);
        return 32'(s);
      end
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input int sh);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    return (sh == 0 || o == 2'b11) ? 1 : sh + 1;
`endif
  endfunction

  // Issues one request, scrambles inputs afterwards, optionally spams start while busy.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [4:0] sh,
                        input logic [31:0] d, input logic [31:0] expv, input int lat, input bit noise);
    int first, ndone, nbusy;
    logic [31:0] got;
    first = 0; ndone = 0; nbusy = 0; got = '0;
    @(negedge clk);
    start = 1'b1; op = o; shamt = sh; data_in = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n;
          got   = data_out;
        end
      end
      op      = 2'($urandom);
      shamt   = 5'($urandom);
      data_in = $urandom;
      start   = noise && (n <= lat);
    end
    start = 1'b0;
    check({nm, " latency"}, 64'(first), 64'(lat));
    check({nm, " done_count"}, 64'(ndone), 64'd1);
    check({nm, " data_out"}, {32'd0, got}, {32'd0, expv});
    check({nm, " busy_cycles"}, 64'(nbusy), 64'(lat));
    check({nm, " hold"}, {32'd0, data_out}, {32'd0, expv});
  endtask

  vec_t vecs[6];

  initial begin
    int bad;
    logic [1:0]  ro;
    logic [4:0]  rs;
    logic [31:0] rd;

    vecs[0] = '{2'b00, 5'd4,  32'h0000_00F1, 32'h0000_0F10, 5,  1'b0};
    vecs[1] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b0};
    vecs[2] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 32, 1'b0};
    vecs[3] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  1'b0};
    vecs[4] = '{2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  1'b0};
    vecs[5] = '{2'b00, 5'd8,  32'h0000_0001, 32'h0000_0100, 9,  1'b1};
`ifdef FAST_SHIFT_EN
    foreach (vecs[i]) vecs[i].lat = 1;
`endif

    reset = 1'b1; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy || data_out != 32'd0) bad++;
    end
    check("reset_idle", 64'(bad), 64'd0);
    check("reset_data_out", {32'd0, data_out}, 64'd0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sh, vecs[i].din,
             vecs[i].expv, vecs[i].lat, vecs[i].noise);

    // Reset in the third cycle of a 10-bit shift.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd10; data_in = 32'h0000_0001;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_data_out", {32'd0, data_out}, 64'd0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) bad++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(bad), 64'd0);
    run_op("after_abort", 2'b00, 5'd10, 32'h0000_0003, 32'h0000_0C00, ref_lat(2'b00, 10), 1'b0);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 31));
      rd = $urandom;
      if (i % 4 == 0) rd[31] = 1'b1;
      run_op($sformatf("rand%0d op%0d sh%0d d%08h", i, ro, rs, rd), ro, rs, rd,
             ref_shift(ro, int'(rs), rd), ref_lat(ro, int'(rs)), i[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
